// File: rtl/simmem_pkg.sv
// Shared types and default sizes for the simulated-memory release scheduler.
package simmem_pkg;

  localparam int unsigned DefaultIDWidth     = 2;
  localparam int unsigned DefaultDelayWidth  = 8;
  localparam int unsigned DefaultNbSlots     = 8;
  localparam int unsigned DefaultCreditWidth = 4;

  typedef struct packed {
    logic                         valid;
    logic [DefaultIDWidth-1:0]    id;
    logic [DefaultDelayWidth-1:0] counter;
  } slot_t;

endpackage

// File: rtl/simmem_delay_slot.sv
// One delay countdown: loads an ID and latency, counts down to zero and
// then holds there (expired) until the scheduler clears it.
module simmem_delay_slot
  import simmem_pkg::*;
#(
  parameter int unsigned IDWidth    = DefaultIDWidth,
  parameter int unsigned DelayWidth = DefaultDelayWidth
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  load_i,
  input  logic                  clear_i,
  input  logic [IDWidth-1:0]    id_i,
  input  logic [DelayWidth-1:0] delay_i,
  output logic                  valid_o,
  output logic [IDWidth-1:0]    id_o,
  output logic                  expired_o
);

  logic                  valid_q, valid_d;
  logic [IDWidth-1:0]    id_q, id_d;
  logic [DelayWidth-1:0] counter_q, counter_d;

  // Next-state: load has priority and skips the decrement on its own edge.
  always_comb begin
    valid_d   = valid_q;
    id_d      = id_q;
    counter_d = counter_q;
    if (load_i) begin
      valid_d   = 1'b1;
      id_d      = id_i;
      counter_d = delay_i;
    end else if (clear_i) begin
      valid_d   = 1'b0;
      counter_d = {DelayWidth{1'b0}};
    end else if (valid_q && (counter_q != {DelayWidth{1'b0}})) begin
      counter_d = counter_q - DelayWidth'(1);
    end else begin
      counter_d = counter_q;
    end
  end

  // Slot state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q   <= 1'b0;
      id_q      <= {IDWidth{1'b0}};
      counter_q <= {DelayWidth{1'b0}};
    end else begin
      valid_q   <= valid_d;
      id_q      <= id_d;
      counter_q <= counter_d;
    end
  end

  assign valid_o   = valid_q;
  assign id_o      = id_q;
  assign expired_o = valid_q && (counter_q == {DelayWidth{1'b0}});

endmodule

// File: rtl/simmem_release_scheduler.sv
// Per-ID release controller: counts delay requests down in slots and turns
// expiries into per-ID release credits that gate the linked-list bank.
module simmem_release_scheduler
  import simmem_pkg::*;
#(
  parameter int unsigned IDWidth     = DefaultIDWidth,
  parameter int unsigned NbSlots     = DefaultNbSlots,
  parameter int unsigned DelayWidth  = DefaultDelayWidth,
  parameter int unsigned CreditWidth = DefaultCreditWidth
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         delay_valid_i,
  output logic                         delay_ready_o,
  input  logic [IDWidth-1:0]           delay_id_i,
  input  logic [DelayWidth-1:0]        delay_i,
  output logic [2**IDWidth-1:0]        release_en_o,
  input  logic                         released_valid_i,
  input  logic [IDWidth-1:0]           released_id_i,
  output logic [$clog2(NbSlots+1)-1:0] free_slots_o,
  output logic                         underflow_o
);

  localparam int unsigned NbIds     = 2**IDWidth;
  localparam int unsigned FreeWidth = $clog2(NbSlots+1);
  localparam logic [CreditWidth-1:0] CreditMax = {CreditWidth{1'b1}};

  logic [NbSlots-1:0] slot_valid_s, slot_free_s, slot_expired_s;
  logic [NbSlots-1:0] slot_load_s, slot_clear_s;
  logic [IDWidth-1:0] slot_id_s [NbSlots];

  logic                   accept_s, taken_s;
  logic [NbIds-1:0]       dec_s, room_s, seen_s, inc_s;
  logic [CreditWidth-1:0] credit_q [NbIds];
  logic [CreditWidth-1:0] credit_d [NbIds];
  logic                   underflow_q, underflow_d;
  logic [FreeWidth-1:0]   free_cnt_s;

  for (genvar s = 0; s < NbSlots; s++) begin : g_slot
    simmem_delay_slot #(
      .IDWidth   (IDWidth),
      .DelayWidth(DelayWidth)
    ) u_slot (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .load_i   (slot_load_s[s]),
      .clear_i  (slot_clear_s[s]),
      .id_i     (delay_id_i),
      .delay_i  (delay_i),
      .valid_o  (slot_valid_s[s]),
      .id_o     (slot_id_s[s]),
      .expired_o(slot_expired_s[s])
    );
  end

  assign slot_free_s = ~slot_valid_s;

  // Lowest-index free slot takes an accepted request.
  always_comb begin
    accept_s = delay_valid_i & delay_ready_o;
    taken_s  = 1'b0;
    for (int s = 0; s < NbSlots; s++) begin
      slot_load_s[s] = accept_s & slot_free_s[s] & ~taken_s;
      taken_s        = taken_s | slot_free_s[s];
    end
  end

  // A full credit counter can still absorb a retirement when it is consumed on the same edge.
  always_comb begin
    for (int i = 0; i < NbIds; i++) begin
      dec_s[i]  = released_valid_i & (released_id_i == IDWidth'(i));
      room_s[i] = (credit_q[i] != CreditMax) | dec_s[i];
    end
  end

  // Per ID, only the lowest-index expired slot retires, and only with credit room.
  always_comb begin
    slot_clear_s = {NbSlots{1'b0}};
    seen_s       = {NbIds{1'b0}};
    for (int i = 0; i < NbIds; i++) begin
      for (int s = 0; s < NbSlots; s++) begin
        slot_clear_s[s] = slot_clear_s[s] |
                          (slot_expired_s[s] & (slot_id_s[s] == IDWidth'(i)) & ~seen_s[i] & room_s[i]);
        seen_s[i]       = seen_s[i] | (slot_expired_s[s] & (slot_id_s[s] == IDWidth'(i)));
      end
    end
    inc_s = seen_s & room_s;
  end

  // Credit next-state and sticky underflow on a release against an empty credit.
  always_comb begin
    underflow_d = underflow_q;
    for (int i = 0; i < NbIds; i++) begin
      credit_d[i] = credit_q[i];
      case ({inc_s[i], dec_s[i]})
        2'b10: credit_d[i] = credit_q[i] + CreditWidth'(1);
        2'b01: begin
          if (credit_q[i] == {CreditWidth{1'b0}}) begin
            underflow_d = 1'b1;
          end else begin
            credit_d[i] = credit_q[i] - CreditWidth'(1);
          end
        end
        default: credit_d[i] = credit_q[i];
      endcase
    end
  end

  // Credit and error registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NbIds; i++) begin
        credit_q[i] <= {CreditWidth{1'b0}};
      end
      underflow_q <= 1'b0;
    end else begin
      for (int i = 0; i < NbIds; i++) begin
        credit_q[i] <= credit_d[i];
      end
      underflow_q <= underflow_d;
    end
  end

  // Free-slot popcount over the slot valid registers.
  always_comb begin
    free_cnt_s = {FreeWidth{1'b0}};
    for (int s = 0; s < NbSlots; s++) begin
      free_cnt_s = free_cnt_s + FreeWidth'(slot_free_s[s]);
    end
  end

  // Release enables straight from the credit registers.
  always_comb begin
    for (int i = 0; i < NbIds; i++) begin
      release_en_o[i] = (credit_q[i] != {CreditWidth{1'b0}});
    end
  end

  assign delay_ready_o = |slot_free_s;
  assign free_slots_o  = free_cnt_s;
  assign underflow_o   = underflow_q;

endmodule

// File: tb/tb_simmem_release_scheduler.sv
// Self-checking bench: directed vector table, hand-written corner sequences
// and randomized traffic compared against a queue-based reference model.
module tb_simmem_release_scheduler;

  localparam int NB_IDS   = 4;
  localparam int NB_SLOTS = 8;
  localparam int CMAX     = 15;

  logic       clk = 1'b0;
  logic       rst_ni = 1'b0;
  logic       delay_valid = 1'b0;
  logic [1:0] delay_id = 2'd0;
  logic [7:0] delay = 8'd0;
  logic       rel_valid = 1'b0;
  logic [1:0] rel_id = 2'd0;
  logic       delay_ready;
  logic [3:0] release_en;
  logic [3:0] free_slots;
  logic       underflow;

  int n_checks = 0;
  int n_pass   = 0;

  simmem_release_scheduler dut (
    .clk_i           (clk),
    .rst_ni          (rst_ni),
    .delay_valid_i   (delay_valid),
    .delay_ready_o   (delay_ready),
    .delay_id_i      (delay_id),
    .delay_i         (delay),
    .release_en_o    (release_en),
    .released_valid_i(rel_valid),
    .released_id_i   (rel_id),
    .free_slots_o    (free_slots),
    .underflow_o     (underflow)
  );

  always #5 clk = ~clk;

  // Reference model: outstanding requests with remaining time, plus integer credits.
  typedef struct { int id; int rem; } req_t;
  req_t pend[$];
  int   credit[NB_IDS];
  bit   m_uf;

  function automatic void model_reset();
    pend.delete();
    for (int i = 0; i < NB_IDS; i++) credit[i] = 0;
    m_uf = 1'b0;
  endfunction

  function automatic void model_step();
    req_t nxt[$];
    req_t r;
    bit [3:0] inc = 4'b0;
    bit acc;
    acc = delay_valid && (pend.size() < NB_SLOTS);
    foreach (pend[k]) begin
      r = pend[k];
      if (r.rem == 0) begin
        if (!inc[r.id] && (credit[r.id] < CMAX || (rel_valid && int'(rel_id) == r.id)))
          inc[r.id] = 1'b1;
        else
          nxt.push_back(r);
      end else begin
        r.rem = r.rem - 1;
        nxt.push_back(r);
      end
    end
    for (int i = 0; i < NB_IDS; i++) begin
      bit dec;
      dec = rel_valid && (int'(rel_id) == i);
      if (inc[i] && !dec) credit[i]++;
      else if (dec && !inc[i]) begin
        if (credit[i] == 0) m_uf = 1'b1;
        else credit[i]--;
      end
    end
    if (acc) begin
      r.id  = int'(delay_id);
      r.rem = int'(delay);
      nxt.push_back(r);
    end
    pend = nxt;
  endfunction

  function automatic logic [3:0] model_rel();
    logic [3:0] v;
    for (int i = 0; i < NB_IDS; i++) v[i] = (credit[i] != 0);
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    delay_valid = 1'b0;
    rel_valid   = 1'b0;
    rst_ni      = 1'b0;
    model_reset();
    #2;
    rst_ni = 1'b1;
  endtask

  typedef struct {
    logic       v;
    logic [1:0] id;
    logic [7:0] d;
    logic       rv;
    logic [1:0] rid;
    logic [3:0] e_rel;
    logic       e_rdy;
    logic [3:0] e_free;
    logic       e_uf;
  } vec_t;
  vec_t tbl[10];

  int  n;
  bit  found;

  initial begin
    tbl[0] = '{1'b1, 2'd2, 8'd1, 1'b0, 2'd0, 4'b0000, 1'b1, 4'd7, 1'b0};
    tbl[1] = '{1'b0, 2'd0, 8'd0, 1'b0, 2'd0, 4'b0000, 1'b1, 4'd7, 1'b0};
    tbl[2] = '{1'b0, 2'd0, 8'd0, 1'b0, 2'd0, 4'b0100, 1'b1, 4'd8, 1'b0};
    tbl[3] = '{1'b1, 2'd1, 8'd0, 1'b1, 2'd2, 4'b0000, 1'b1, 4'd7, 1'b0};
    tbl[4] = '{1'b0, 2'd0, 8'd0, 1'b0, 2'd0, 4'b0010, 1'b1, 4'd8, 1'b0};
    tbl[5] = '{1'b0, 2'd0, 8'd0, 1'b1, 2'd0, 4'b0010, 1'b1, 4'd8, 1'b1};
    tbl[6] = '{1'b0, 2'd0, 8'd0, 1'b1, 2'd1, 4'b0000, 1'b1, 4'd8, 1'b1};
    tbl[7] = '{1'b1, 2'd3, 8'd0, 1'b0, 2'd0, 4'b0000, 1'b1, 4'd7, 1'b1};
    tbl[8] = '{1'b1, 2'd0, 8'd0, 1'b0, 2'd0, 4'b1000, 1'b1, 4'd7, 1'b1};
    tbl[9] = '{1'b0, 2'd0, 8'd0, 1'b0, 2'd0, 4'b1001, 1'b1, 4'd8, 1'b1};

    // Reset state, both during and after reset.
    model_reset();
    @(posedge clk); #1;
    check("rst_release_en", release_en, 4'b0000);
    check("rst_ready", delay_ready, 1'b1);
    check("rst_free", free_slots, 4'd8);
    check("rst_underflow", underflow, 1'b0);
    #2 rst_ni = 1'b1;
    tick(); tick();
    check("idle_free", free_slots, 4'd8);
    check("idle_release_en", release_en, 4'b0000);

    // Directed vector table.
    for (int r = 0; r < 10; r++) begin
      delay_valid = tbl[r].v;  delay_id = tbl[r].id; delay = tbl[r].d;
      rel_valid   = tbl[r].rv; rel_id   = tbl[r].rid;
      tick();
      check($sformatf("tbl%0d_release_en", r), release_en, tbl[r].e_rel);
      check($sformatf("tbl%0d_ready", r), delay_ready, tbl[r].e_rdy);
      check($sformatf("tbl%0d_free", r), free_slots, tbl[r].e_free);
      check($sformatf("tbl%0d_underflow", r), underflow, tbl[r].e_uf);
    end
    delay_valid = 1'b0; rel_valid = 1'b0;

    // id=2, d=5: enable appears exactly six edges after acceptance.
    do_reset();
    delay_valid = 1'b1; delay_id = 2'd2; delay = 8'd5;
    tick();
    delay_valid = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      check($sformatf("d5_edge%0d_release_en", k), release_en, (k == 6) ? 4'b0100 : 4'b0000);
    end
    rel_valid = 1'b1; rel_id = 2'd2;
    tick();
    rel_valid = 1'b0;
    check("d5_consumed_release_en", release_en, 4'b0000);

    // Fill all slots, then wait (bounded) for the first retirement to free one.
    do_reset();
    for (int k = 0; k < 8; k++) begin
      delay_valid = 1'b1; delay_id = 2'(k % 4); delay = 8'd20;
      tick();
    end
    delay_valid = 1'b0;
    check("full_ready", delay_ready, 1'b0);
    check("full_free", free_slots, 4'd0);
    n = 0; found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      tick();
      n++;
      if (delay_ready) found = 1'b1;
    end
    check("full_reopen_latency", n, 14);
    check("full_reopen_free", free_slots, 4'd1);
    check("full_reopen_release_en", release_en, 4'b0001);

    // Two zero-delay id=1 requests build two credits.
    do_reset();
    delay_valid = 1'b1; delay_id = 2'd1; delay = 8'd0;
    tick(); tick();
    delay_valid = 1'b0;
    tick();
    check("cr2_release_en", release_en, 4'b0010);
    rel_valid = 1'b1; rel_id = 2'd1;
    tick();
    check("cr2_after_one", release_en, 4'b0010);
    tick();
    rel_valid = 1'b0;
    check("cr2_after_two", release_en, 4'b0000);
    check("cr2_underflow", underflow, 1'b0);

    // Credit saturation: 16th id=3 request stays parked until a release.
    do_reset();
    delay_valid = 1'b1; delay_id = 2'd3; delay = 8'd0;
    for (int k = 0; k < 16; k++) tick();
    delay_valid = 1'b0;
    tick(); tick();
    check("sat_free_blocked", free_slots, 4'd7);
    rel_valid = 1'b1; rel_id = 2'd3;
    tick();
    check("sat_free_after_release", free_slots, 4'd8);
    for (int k = 1; k <= 15; k++) begin
      tick();
      check($sformatf("sat_drain%0d", k), release_en, (k < 15) ? 4'b1000 : 4'b0000);
    end
    rel_valid = 1'b0;
    check("sat_underflow", underflow, 1'b0);

    // Sticky underflow, then async reset mid-countdown with no clock edge.
    do_reset();
    delay_valid = 1'b1; delay_id = 2'd1; delay = 8'd20;
    tick();
    delay_valid = 1'b0;
    rel_valid = 1'b1; rel_id = 2'd0;
    tick();
    rel_valid = 1'b0;
    check("uf_set", underflow, 1'b1);
    tick(); tick(); tick();
    check("uf_sticky", underflow, 1'b1);
    check("uf_free_busy", free_slots, 4'd7);
    #2 rst_ni = 1'b0;
    #1;
    check("async_rst_underflow", underflow, 1'b0);
    check("async_rst_free", free_slots, 4'd8);
    check("async_rst_ready", delay_ready, 1'b1);
    model_reset();
    #2 rst_ni = 1'b1;

    // Randomized traffic against the reference model.
    @(posedge clk); #1;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) do_reset();
      delay_valid = ($urandom_range(0, 2) != 0);
      delay_id    = 2'($urandom_range(0, 3));
      delay       = 8'($urandom_range(0, 11));
      rel_id      = 2'($urandom_range(0, 3));
      rel_valid   = ($urandom_range(0, 1) == 1) &&
                    (credit[rel_id] != 0 || $urandom_range(0, 99) == 0);
      tick();
      check($sformatf("rnd%0d_release_en", c), release_en, model_rel());
      check($sformatf("rnd%0d_ready", c), delay_ready, (pend.size() < NB_SLOTS));
      check($sformatf("rnd%0d_free", c), free_slots, NB_SLOTS - pend.size());
      check($sformatf("rnd%0d_underflow", c), underflow, m_uf);
    end
    delay_valid = 1'b0; rel_valid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/simmem_release_scheduler.md
# simmem_release_scheduler

Per-ID release controller for `simmem_linkedlist_bank`. Accepts delay requests, each an AXI ID plus a latency in cycles, and counts each one down in a free slot. When a slot expires it grants one release credit to that ID. The block drives the bank's `release_en_i` from those credits and consumes one credit per response the bank emits, so the bank models the configured memory latency per transaction.

## Interface
Parameters:
- `IDWidth`, 2: width of the AXI ID. Sets the number of ID queues, 2**IDWidth.
- `NbSlots`, 8: number of concurrent delay countdowns.
- `DelayWidth`, 8: width of the delay field.
- `CreditWidth`, 4: width of each per-ID credit counter. Credits saturate at 2**CreditWidth-1.

Ports:
- `clk_i`  in  1  single clock, rising edge.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `delay_valid_i`  in  1  delay request valid.
- `delay_ready_o`  out  1  a free slot exists.
- `delay_id_i`  in  IDWidth  ID of the request.
- `delay_i`  in  DelayWidth  latency in cycles.
- `release_en_o`  out  2**IDWidth  per-ID release enable, connected to the bank's `release_en_i`.
- `released_valid_i`  in  1  bank output handshake fired (`out_valid_o & out_ready_i`).
- `released_id_i`  in  IDWidth  ID of the released entry, taken from the low IDWidth bits of the bank's `data_o`.
- `free_slots_o`  out  $clog2(NbSlots+1)  number of free slots.
- `underflow_o`  out  1  sticky error: a release was reported for an ID with zero credit.

## Operation
- Slot state: `valid`, `id`, `counter[DelayWidth]`.
- Credit state: one `credit[CreditWidth]` per ID.
- Reset (async, while `rst_ni`=0):
  - all slots invalid; counters 0; credits 0; `underflow_o`=0.
  - outputs: `delay_ready_o`=1, `release_en_o`=0, `free_slots_o`=NbSlots.
- Accept:
  - On an edge with `delay_valid_i & delay_ready_o`, the lowest-index invalid slot takes `valid`=1, `id`=`delay_id_i`, `counter`=`delay_i`.
  - `delay_ready_o` = OR of the inverted slot `valid` bits. It is computed from registers only and never depends on `delay_valid_i`.
- Countdown: each edge, a valid slot with `counter`!=0 decrements. A slot that was accepted on that same edge does not decrement.
- Expiry: a valid slot with `counter`==0 is eligible.
  - Per ID, only the lowest-index eligible slot retires on an edge.
  - Retiring requires credit room: `credit[id]` < max, or a decrement of the same ID on the same edge.
  - On retire, the slot becomes invalid and `credit[id]` increments.
  - A blocked eligible slot stays valid at 0 and is retried every cycle.
- Release: `release_en_o[i]` = (`credit[i]` != 0), driven combinationally from the credit registers.
- Consume: on an edge with `released_valid_i`, `credit[released_id_i]` decrements.
  - If that credit is 0 and no increment for the same ID occurs on that edge, the credit stays 0 and `underflow_o` sets. It stays set until reset.
- Simultaneous increment and decrement on the same ID: net credit change 0.
- A slot freed on edge t is reusable from edge t+1 only. `delay_ready_o` and `free_slots_o` update after the edge.
- `free_slots_o` = count of invalid slots, registered-derived.

## Timing
- Request accepted at edge t with delay d:
  - countdown ends at edge t+d;
  - credit increments at edge t+d+1;
  - `release_en_o[id]` is high during cycle t+d+1.
- Delay 0: `release_en_o[id]` is high in the cycle after acceptance.
- Throughput: one request accepted per cycle. Up to 2**IDWidth slots retire per cycle, one per ID.
- When full (`free_slots_o`=0), `delay_ready_o`=0 until the edge after a retirement.
- No combinational path from any input to `delay_ready_o`, `release_en_o` or `free_slots_o`.
- Reset asserted mid-operation clears all state immediately. In-flight requests are dropped.

## Structure
- Package `simmem_pkg`:
  - slot struct typedef (`valid`, `id`, `counter`);
  - default parameter constants (`IDWidth`, `DelayWidth`).
- Sub-module `simmem_delay_slot`: one slot with load/decrement/clear logic and an `expired_o` flag. Instantiated NbSlots times.
- The top level holds:
  - lowest-free-slot priority encoder;
  - per-ID lowest-eligible selection;
  - credit counters;
  - free-slot popcount.

## Test plan
- After reset, with no stimulus → `release_en_o`=0000, `delay_ready_o`=1, `free_slots_o`=8, `underflow_o`=0.
- Request id=2, d=5 accepted at edge 10 → `release_en_o`=0100 first seen in cycle 16. One `released_valid_i` with id 2 → `release_en_o` returns to 0 in the next cycle.
- Fill 8 slots with d=20 on IDs 0..3 → `delay_ready_o`=0 and `free_slots_o`=0. First retirement (lowest-index expired slot, one per ID) → `delay_ready_o`=1 on the following cycle.
- Two id=1 requests, d=0, on consecutive edges → `credit[1]` reaches 2. Two releases then bring it to 0, and `underflow_o` stays 0.
- 16 id=3 requests, d=0, no releases → credit saturates at 15 and the 16th slot stays valid. One release → that slot retires on the same edge and credit stays 15.
- Release id=0 with zero credit → `underflow_o`=1 and remains set. Assert `rst_ni` low mid-countdown → all slots freed and `underflow_o`=0 with no clock edge.
